// File: rtl/data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : data_mem                                                       |
// | Purpose  : RV32I load/store data memory with fixed wait states.           |
// |            Optional fault reporting when DATA_MEM_ERR_EN is defined.      |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module data_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  output logic        ready,
  output logic        done,
  output logic [31:0] r_data,
  output logic        err
);

  localparam int         c_aw        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait_init = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_go;
  logic          w_acc_we;
  logic [2:0]    w_acc_f3;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wd;
  logic [c_aw-1:0] w_idx;
  logic [1:0]    w_size;
  logic [1:0]    w_off;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_word;
  logic [31:0]   w_sh;
  logic [31:0]   w_ld;
  logic          w_err;
  logic          w_unused_addr;

  // With zero wait states the access resolves on the accepting edge itself,
  // so the live inputs stand in for the not-yet-captured request.
  assign w_go = (r_state == S_IDLE && req && (WAIT_STATES == 0)) ||
                (r_state == S_WAIT && r_cnt == 4'd0);

  assign w_acc_we   = (r_state == S_IDLE) ? we     : r_we;
  assign w_acc_f3   = (r_state == S_IDLE) ? func3  : r_f3;
  assign w_acc_addr = (r_state == S_IDLE) ? addr   : r_addr;
  assign w_acc_wd   = (r_state == S_IDLE) ? w_data : r_wd;

  assign w_idx         = w_acc_addr[c_aw+1:2];
  assign w_unused_addr = ^w_acc_addr[31:c_aw+2];

  // Size: 0 = byte, 1 = half, 2 = word; unknown codes fall back to word.
  always_comb begin
    w_size = 2'd2;
    if (w_acc_f3[1:0] != 2'b11 && !(w_acc_we && w_acc_f3[2]))
      w_size = w_acc_f3[1:0];
    case (w_size)
      2'd0:    w_off = w_acc_addr[1:0];
      2'd1:    w_off = {w_acc_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef DATA_MEM_ERR_EN
  logic w_ill;
  logic w_mis;
  always_comb begin
    w_ill = w_acc_we ? (w_acc_f3[2] | (w_acc_f3[1:0] == 2'b11))
                     : ((w_acc_f3[1:0] == 2'b11) | (w_acc_f3[2] & w_acc_f3[1]));
    w_mis = ((w_size == 2'd1) & w_acc_addr[0]) |
            ((w_size == 2'd2) & (w_acc_addr[1:0] != 2'b00));
  end
  assign w_err = w_ill | w_mis;
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    case (w_size)
      2'd0: begin
        w_be = 4'b0001 << w_off;
        w_wd = {4{w_acc_wd[7:0]}};
      end
      2'd1: begin
        w_be = w_off[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_acc_wd[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = w_acc_wd;
      end
    endcase
  end

  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {w_off, 3'b000};

  always_comb begin
    case (w_size)
      2'd0:    w_ld = {{24{~w_acc_f3[2] & w_sh[7]}}, w_sh[7:0]};
      2'd1:    w_ld = {{16{~w_acc_f3[2] & w_sh[15]}}, w_sh[15:0]};
      default: w_ld = w_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= 32'd0;
      r_wd    <= 32'd0;
      ready   <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      r_data  <= 32'd0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      r_data <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we   <= we;
            r_f3   <= func3;
            r_addr <= addr;
            r_wd   <= w_data;
            ready  <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_init;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        default: begin
          r_state <= S_IDLE;
          ready   <= 1'b1;
        end
      endcase
      if (w_go) begin
        done   <= 1'b1;
        err    <= w_err;
        r_data <= (w_acc_we || w_err) ? 32'd0 : w_ld;
      end
    end
  end

  // rst gating keeps an aborted or reset-time access from touching the array.
  always_ff @(posedge clk) begin
    if (rst && w_go && w_acc_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_data_mem                                                    |
// | Purpose  : Scoreboard bench for data_mem (DATA_MEM_ERR_EN aware).         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_data_mem;

  localparam int DEPTH = 256;
  localparam int WS    = 1;
  localparam int P     = WS + 2;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] w_data = 32'd0;
  logic        ready;
  logic        done;
  logic [31:0] r_data;
  logic        err;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [32:0] exp_q [$];
  logic [31:0] model [DEPTH];

  data_mem #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .we     (we),
    .func3  (func3),
    .addr   (addr),
    .w_data (w_data),
    .ready  (ready),
    .done   (done),
    .r_data (r_data),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input op_t o);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_ready: ready=%b required 1", ready);
    end
    exp_q.push_back({o.er, o.rd});
    req = 1'b1; we = o.we; func3 = o.f3; addr = o.a; w_data = o.wd;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] ord, output logic oerr, output int lat);
    lat = -1; ord = 'x; oerr = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; ord = r_data; oerr = err;
        break;
      end
    end
  endtask

  task automatic exec(input op_t o, output logic [31:0] ord, output logic oerr, output int lat);
    issue(o);
    wait_done(ord, oerr, lat);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({ready, done, err, r_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_async: ready=%b done=%b err=%b r_data=%h required 1 0 0 00000000",
               ready, done, err, r_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ready, done, err, r_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b done=%b err=%b r_data=%h required 1 0 0 00000000",
               ready, done, err, r_data);
    end
  endtask

  task automatic test_store_load();
    op_t t [2];
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    t[0] = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    t[1] = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
    for (int i = 0; i < 2; i++) begin
      exec(t[i], ord, oerr, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({oerr, ord} !== exp || lat != WS) begin
        n_fail++;
        $display("FAIL store_load[%0d]: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
                 i, oerr, ord, lat, exp[32], exp[31:0], WS);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_width[%0d]: done=%b required 0", i, done);
      end
    end
  endtask

  task automatic test_byte_lanes();
    op_t t [10];
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    t[0] = '{1'b1, 3'b000, 32'h11, 32'h80,       32'h0,        1'b0};
    t[1] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD80EF, 1'b0};
    t[2] = '{1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0};
    t[3] = '{1'b0, 3'b100, 32'h11, 32'h0,        32'h00000080, 1'b0};
    t[4] = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
    t[5] = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0};
    t[6] = '{1'b1, 3'b001, 32'h12, 32'hABCD1234, 32'h0,        1'b0};
    t[7] = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h123480EF, 1'b0};
    t[8] = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0};
    t[9] = '{1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFF80EF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      exec(t[i], ord, oerr, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({oerr, ord} !== exp || lat != WS) begin
        n_fail++;
        $display("FAIL byte_lanes[%0d]: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
                 i, oerr, ord, lat, exp[32], exp[31:0], WS);
      end
    end
  endtask

  task automatic test_wrap();
    op_t t [4];
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    t[0] = '{1'b1, 3'b010, 32'h400,      32'h12345678, 32'h0,        1'b0};
    t[1] = '{1'b0, 3'b010, 32'h0,        32'h0,        32'h12345678, 1'b0};
    t[2] = '{1'b1, 3'b010, 32'h3FC,      32'hA0B0C0D0, 32'h0,        1'b0};
    t[3] = '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,        32'hA0B0C0D0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      exec(t[i], ord, oerr, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({oerr, ord} !== exp || lat != WS) begin
        n_fail++;
        $display("FAIL wrap[%0d]: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
                 i, oerr, ord, lat, exp[32], exp[31:0], WS);
      end
    end
  endtask

  task automatic test_misaligned();
    op_t t [7];
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    t[0] = '{1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0};
`ifdef DATA_MEM_ERR_EN
    t[1] = '{1'b1, 3'b010, 32'h22, 32'h11223344, 32'h0,        1'b1};
    t[2] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0};
    t[3] = '{1'b0, 3'b001, 32'h21, 32'h0,        32'h0,        1'b1};
    t[4] = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b1};
    t[5] = '{1'b1, 3'b100, 32'h20, 32'hFF,       32'h0,        1'b1};
    t[6] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'hA5A5A5A5, 1'b0};
`else
    t[1] = '{1'b1, 3'b010, 32'h22, 32'h11223344, 32'h0,        1'b0};
    t[2] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h11223344, 1'b0};
    t[3] = '{1'b0, 3'b001, 32'h21, 32'h0,        32'h00003344, 1'b0};
    t[4] = '{1'b0, 3'b011, 32'h20, 32'h0,        32'h11223344, 1'b0};
    t[5] = '{1'b1, 3'b100, 32'h20, 32'hFF,       32'h0,        1'b0};
    t[6] = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h000000FF, 1'b0};
`endif
    for (int i = 0; i < 7; i++) begin
      exec(t[i], ord, oerr, lat);
      exp = exp_q.pop_front();
      n_cmp++;
      if ({oerr, ord} !== exp || lat != WS) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
                 i, oerr, ord, lat, exp[32], exp[31:0], WS);
      end
    end
  endtask

  task automatic test_random();
    op_t o;
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    int idx; int lane; logic [7:0] b;
    for (int i = 0; i < 6; i++) begin
      idx  = 64 + i;
      lane = $urandom_range(0, 3);
      b    = 8'($urandom_range(0, 255));
      model[idx] = $urandom;
      for (int s = 0; s < 4; s++) begin
        case (s)
          0: o = '{1'b1, 3'b010, 32'(idx * 4), model[idx], 32'h0, 1'b0};
          1: begin
            o = '{1'b1, 3'b000, 32'(idx * 4 + lane), {24'h0, b}, 32'h0, 1'b0};
            model[idx][8*lane +: 8] = b;
          end
          2: o = '{1'b0, 3'b010, 32'(idx * 4), 32'h0, model[idx], 1'b0};
          default: o = '{1'b0, 3'b100, 32'(idx * 4 + lane), 32'h0, {24'h0, b}, 1'b0};
        endcase
        exec(o, ord, oerr, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if ({oerr, ord} !== exp || lat != WS) begin
          n_fail++;
          $display("FAIL random[%0d.%0d]: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
                   i, s, oerr, ord, lat, exp[32], exp[31:0], WS);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic exp_rdy; logic exp_done; logic [32:0] exp;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; func3 = 3'b010; addr = 32'h10; w_data = 32'h0;
    for (int j = 0; j < 3; j++) exp_q.push_back({1'b0, 32'h123480EF});
    @(posedge clk);
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      exp_rdy  = ((k % P) == P - 1);
      exp_done = ((k % P) == WS);
      n_cmp++;
      if ({ready, done} !== {exp_rdy, exp_done}) begin
        n_fail++;
        $display("FAIL b2b_hs[%0d]: ready=%b done=%b required ready=%b done=%b",
                 k, ready, done, exp_rdy, exp_done);
      end
      if (done === 1'b1 && exp_q.size() > 0) begin
        pulses++;
        exp = exp_q.pop_front();
        n_cmp++;
        if ({err, r_data} !== exp) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: err=%b r_data=%h required err=%b r_data=%h",
                   k, err, r_data, exp[32], exp[31:0]);
        end
      end
    end
    req = 1'b0;
    n_cmp++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL b2b_count: done pulses=%0d required 3", pulses);
    end
    exp_q.delete();
    repeat (P) @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    op_t o;
    logic [31:0] ord; logic oerr; int lat; logic [32:0] exp;
    o = '{1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0};
    exec(o, ord, oerr, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if ({oerr, ord} !== exp || lat != WS) begin
      n_fail++;
      $display("FAIL rst_wait_setup: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
               oerr, ord, lat, exp[32], exp[31:0], WS);
    end
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 32'h30; w_data = 32'h55555555;
    @(posedge clk); #1;
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready, done, err, r_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_wait_async: ready=%b done=%b err=%b r_data=%h required 1 0 0 00000000",
               ready, done, err, r_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_wait_done[%0d]: done=%b required 0", k, done);
      end
    end
    o = '{1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0};
    exec(o, ord, oerr, lat);
    exp = exp_q.pop_front();
    n_cmp++;
    if ({oerr, ord} !== exp || lat != WS) begin
      n_fail++;
      $display("FAIL rst_wait_mem: err=%b r_data=%h lat=%0d required err=%b r_data=%h lat=%0d",
               oerr, ord, lat, exp[32], exp[31:0], WS);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_wrap();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
